// File: rtl/key_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : key_pkg                                                    |
// | Description : Shared types and constants for the pushbutton input path.  |
// |               deb_state_t is the debouncer state encoding; the 20 ms     |
// |               confirm window at 50 MHz is the default debounce length.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package key_pkg;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    CONF_PRESS = 2'd1,
    PRESS      = 2'd2,
    CONF_REL   = 2'd3
  } deb_state_t;

  // 20 ms at 50 MHz
  localparam int DEB_20MS_50MHZ = 1_000_000;

  // Width of the saturating glitch counter
  localparam int GLITCH_W = 8;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_debouncer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : key_debouncer_if                                           |
// | Description : Signal bundle between a raw pushbutton source and the      |
// |               key debouncer.                                             |
// |   key_raw      raw pad level, active-low, asynchronous                   |
// |   key_clean    debounced level, active-low                               |
// |   busy         a level change is being confirmed                         |
// |   glitch_count saturating count of rejected bounces                      |
// |   master : drives key_raw, observes the results (pad / testbench side)   |
// |   slave  : the debouncer                                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface key_debouncer_if;
  import key_pkg::*;

  logic                key_raw;
  logic                key_clean;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output key_raw,
    input  key_clean,
    input  busy,
    input  glitch_count
  );

  modport slave (
    input  key_raw,
    output key_clean,
    output busy,
    output glitch_count
  );

endinterface : key_debouncer_if
`default_nettype wire

// File: rtl/key_synchronizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_synchronizer                                           |
// | Description : Multi-flop synchroniser bringing an asynchronous pad into  |
// |               the Clock domain. Resets to 1 (the released level of an    |
// |               active-low key) so no false press is seen out of reset.    |
// |   Clock  in  system clock, rising edge                                   |
// |   RST    in  asynchronous active-low reset                               |
// |   d      in  asynchronous input                                          |
// |   q      out synchronised output (last flop of the chain)                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module key_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge Clock or negedge RST) begin
    if (!RST) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule : key_synchronizer
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_debouncer                                              |
// | Description : Debounces one active-low pushbutton. The pad is first      |
// |               synchronised, then a confirm-counter FSM accepts a level   |
// |               change only after DEBOUNCE_CYCLES consecutive stable       |
// |               cycles. Rejected bounces are counted (saturating).         |
// |   Clock             in  system clock, rising edge                        |
// |   RST               in  asynchronous active-low reset                    |
// |   key.key_raw       in  raw pad, active-low                              |
// |   key.key_clean     out debounced level, active-low, registered          |
// |   key.busy          out 1 while in CONF_PRESS / CONF_REL                 |
// |   key.glitch_count  out saturating count of rejected bounces             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module key_debouncer
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEB_20MS_50MHZ
) (
  input  logic            Clock,
  input  logic            RST,
  key_debouncer_if.slave  key
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                w_key_sync;

  deb_state_t          r_state;
  deb_state_t          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_clean;
  logic                w_clean_nxt;
  logic [GLITCH_W-1:0] r_glitch;
  logic [GLITCH_W-1:0] w_glitch_nxt;
  logic [GLITCH_W-1:0] w_glitch_inc;

  key_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .Clock (Clock),
    .RST   (RST),
    .d     (key.key_raw),
    .q     (w_key_sync)
  );

  always_ff @(posedge Clock or negedge RST) begin
    if (!RST) begin
      r_state  <= REL;
      r_cnt    <= '0;
      r_clean  <= 1'b1;
      r_glitch <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clean  <= w_clean_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

  // Saturating increment, used whenever a pending change is abandoned
  assign w_glitch_inc = (r_glitch == GLITCH_MAX) ? r_glitch : r_glitch + 1'b1;

  // A reversal is tested before the terminal count, so a bounce that
  // returns exactly on the last count is still rejected.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_clean_nxt  = r_clean;
    w_glitch_nxt = r_glitch;
    case (r_state)
      REL: begin
        w_clean_nxt = 1'b1;
        if (!w_key_sync) begin
          w_state_nxt = CONF_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      CONF_PRESS: begin
        if (w_key_sync) begin
          w_state_nxt  = REL;
          w_glitch_nxt = w_glitch_inc;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESS;
          w_clean_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESS: begin
        w_clean_nxt = 1'b0;
        if (w_key_sync) begin
          w_state_nxt = CONF_REL;
          w_cnt_nxt   = '0;
        end
      end
      CONF_REL: begin
        if (!w_key_sync) begin
          w_state_nxt  = PRESS;
          w_glitch_nxt = w_glitch_inc;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = REL;
          w_clean_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = REL;
        w_cnt_nxt   = '0;
        w_clean_nxt = 1'b1;
      end
    endcase
  end

  assign key.key_clean    = r_clean;
  assign key.busy         = (r_state == CONF_PRESS) || (r_state == CONF_REL);
  assign key.glitch_count = r_glitch;

endmodule : key_debouncer
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_key_debouncer                                           |
// | Description : Directed self-checking bench for key_debouncer with        |
// |               DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 100-unit clock. A model  |
// |               falling-edge detector stands in for the downstream stage.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_key_debouncer;

  logic Clock = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  key_debouncer_if kif ();

  key_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .Clock (Clock),
    .RST   (RST),
    .key   (kif)
  );

  always #50 Clock = ~Clock;

  // Downstream edge-detect stage: one pulse per press (1->0 of key_clean)
  logic prev_clean;
  int   pulses = 0;
  always @(posedge Clock or negedge RST) begin
    if (!RST) begin
      prev_clean <= 1'b1;
    end else begin
      prev_clean <= kif.key_clean;
      if (prev_clean && !kif.key_clean) pulses <= pulses + 1;
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    kif.key_raw = 1'b0;
    #20;
    RST = 1'b0;
    #1;
    checks++;
    if (kif.key_clean !== 1'b1) begin errors++; $display("FAIL reset_clean: key_clean=%b expected 1", kif.key_clean); end
    checks++;
    if (kif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b expected 0", kif.busy); end
    checks++;
    if (kif.glitch_count !== 8'd0) begin errors++; $display("FAIL reset_glitch: glitch_count=%0d expected 0", kif.glitch_count); end
    repeat (3) tick();
    checks++;
    if (kif.key_clean !== 1'b1) begin errors++; $display("FAIL reset_hold: key_clean=%b expected 1", kif.key_clean); end
    kif.key_raw = 1'b1;
    #20;
    RST = 1'b1;
    repeat (4) tick();
    checks++;
    if (kif.key_clean !== 1'b1 || kif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: key_clean=%b busy=%b expected 1 0", kif.key_clean, kif.busy);
    end
  endtask

  task automatic test_clean_press;
    logic exp_clean, exp_busy;
    kif.key_raw = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_clean = (e >= 7) ? 1'b0 : 1'b1;
      exp_busy  = (e >= 3 && e <= 6);
      checks++;
      if (kif.key_clean !== exp_clean) begin errors++; $display("FAIL press_clean e%0d: key_clean=%b expected %b", e, kif.key_clean, exp_clean); end
      checks++;
      if (kif.busy !== exp_busy) begin errors++; $display("FAIL press_busy e%0d: busy=%b expected %b", e, kif.busy, exp_busy); end
    end
    repeat (3) tick();
    checks++;
    if (kif.key_clean !== 1'b0 || kif.busy !== 1'b0) begin
      errors++; $display("FAIL press_hold: key_clean=%b busy=%b expected 0 0", kif.key_clean, kif.busy);
    end
  endtask

  task automatic test_clean_release;
    logic exp_clean, exp_busy;
    kif.key_raw = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_clean = (e >= 7) ? 1'b1 : 1'b0;
      exp_busy  = (e >= 3 && e <= 6);
      checks++;
      if (kif.key_clean !== exp_clean) begin errors++; $display("FAIL release_clean e%0d: key_clean=%b expected %b", e, kif.key_clean, exp_clean); end
      checks++;
      if (kif.busy !== exp_busy) begin errors++; $display("FAIL release_busy e%0d: busy=%b expected %b", e, kif.busy, exp_busy); end
    end
    checks++;
    if (kif.glitch_count !== 8'd0) begin errors++; $display("FAIL release_glitch: glitch_count=%0d expected 0", kif.glitch_count); end
  endtask

  // raw low for two edges only: confirm starts at edge 3, rejected at edge 5
  task automatic test_bounce;
    logic exp_busy;
    kif.key_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 2) kif.key_raw = 1'b1;
      exp_busy = (e == 3 || e == 4);
      checks++;
      if (kif.key_clean !== 1'b1) begin errors++; $display("FAIL bounce_clean e%0d: key_clean=%b expected 1", e, kif.key_clean); end
      checks++;
      if (kif.busy !== exp_busy) begin errors++; $display("FAIL bounce_busy e%0d: busy=%b expected %b", e, kif.busy, exp_busy); end
    end
    checks++;
    if (kif.glitch_count !== 8'd1) begin errors++; $display("FAIL bounce_glitch: glitch_count=%0d expected 1", kif.glitch_count); end
  endtask

  // raw low for 4 edges: reversal reaches the FSM exactly at terminal count
  task automatic test_window_boundary;
    logic exp_busy;
    kif.key_raw = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 4) kif.key_raw = 1'b1;
      exp_busy = (e >= 3 && e <= 6);
      checks++;
      if (kif.key_clean !== 1'b1) begin errors++; $display("FAIL boundary_clean e%0d: key_clean=%b expected 1", e, kif.key_clean); end
      checks++;
      if (kif.busy !== exp_busy) begin errors++; $display("FAIL boundary_busy e%0d: busy=%b expected %b", e, kif.busy, exp_busy); end
    end
    checks++;
    if (kif.glitch_count !== 8'd2) begin errors++; $display("FAIL boundary_glitch: glitch_count=%0d expected 2", kif.glitch_count); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 100; i++) begin
      kif.key_raw = 1'b0;
      tick();
      kif.key_raw = 1'b1;
      tick();
      tick();
    end
    repeat (4) tick();
    checks++;
    if (kif.glitch_count !== 8'd102) begin errors++; $display("FAIL sat_partial: glitch_count=%0d expected 102", kif.glitch_count); end
    for (int i = 0; i < 200; i++) begin
      kif.key_raw = 1'b0;
      tick();
      kif.key_raw = 1'b1;
      tick();
      tick();
    end
    repeat (4) tick();
    checks++;
    if (kif.glitch_count !== 8'd255) begin errors++; $display("FAIL sat_full: glitch_count=%0d expected 255", kif.glitch_count); end
    checks++;
    if (kif.key_clean !== 1'b1 || kif.busy !== 1'b0) begin
      errors++; $display("FAIL sat_idle: key_clean=%b busy=%b expected 1 0", kif.key_clean, kif.busy);
    end
  endtask

  task automatic test_reset_mid_confirm;
    logic exp_clean, exp_busy;
    kif.key_raw = 1'b0;
    repeat (5) tick();
    checks++;
    if (kif.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: busy=%b expected 1", kif.busy); end
    #10;
    RST = 1'b0;
    #1;
    checks++;
    if (kif.key_clean !== 1'b1 || kif.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_state: key_clean=%b busy=%b expected 1 0", kif.key_clean, kif.busy);
    end
    checks++;
    if (kif.glitch_count !== 8'd0) begin errors++; $display("FAIL midrst_glitch: glitch_count=%0d expected 0", kif.glitch_count); end
    #20;
    RST = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_clean = (e >= 7) ? 1'b0 : 1'b1;
      exp_busy  = (e >= 3 && e <= 6);
      checks++;
      if (kif.key_clean !== exp_clean) begin errors++; $display("FAIL midrst_clean e%0d: key_clean=%b expected %b", e, kif.key_clean, exp_clean); end
      checks++;
      if (kif.busy !== exp_busy) begin errors++; $display("FAIL midrst_busy e%0d: busy=%b expected %b", e, kif.busy, exp_busy); end
    end
  endtask

  task automatic test_chain;
    int start;
    kif.key_raw = 1'b1;
    repeat (10) tick();
    checks++;
    if (kif.key_clean !== 1'b1) begin errors++; $display("FAIL chain_released: key_clean=%b expected 1", kif.key_clean); end
    start = pulses;
    for (int g = 0; g < 3; g++) begin
      kif.key_raw = 1'b0;
      tick();
      tick();
      kif.key_raw = 1'b1;
      tick();
      tick();
    end
    kif.key_raw = 1'b0;
    repeat (12) tick();
    checks++;
    if (kif.key_clean !== 1'b0) begin errors++; $display("FAIL chain_pressed: key_clean=%b expected 0", kif.key_clean); end
    checks++;
    if (kif.glitch_count !== 8'd3) begin errors++; $display("FAIL chain_glitch: glitch_count=%0d expected 3", kif.glitch_count); end
    repeat (10) tick();
    checks++;
    if (pulses - start !== 1) begin errors++; $display("FAIL chain_pulses: pulses=%0d expected 1", pulses - start); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_window_boundary();
    test_saturate();
    test_reset_mid_confirm();
    test_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_key_debouncer
`default_nettype wire
